// File: rtl/wb_stage.sv
// Write-back stage: drives the register-file write port from ALU results or returned load data.
// Optional WB_LOAD_BYPASS_EN: load data is written in the same cycle as ld_valid.
module wb_stage #(
    parameter int DATA_W     = 32,
    parameter int LD_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic              mem_wb_en,
    input  logic              mem_read_en,
    input  logic [3:0]        mem_dest,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              writeBackEn,
    output logic [3:0]        destWB,
    output logic [DATA_W-1:0] valueWB,
    output logic              pend_valid,
    output logic [3:0]        pend_dest,
    output logic              ld_err
);

    typedef enum logic [1:0] {IDLE, WAIT_LD, WRITE} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(LD_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              wb_en_q, wb_en_d;
    logic [3:0]        dest_q, dest_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              pend_valid_q, pend_valid_d;
    logic [3:0]        pend_dest_q, pend_dest_d;
    logic              ld_err_q, ld_err_d;
    logic              accept;
    logic              ld_fire;

    assign mem_ready = (state_q != WAIT_LD);
    assign accept    = mem_valid && mem_ready;
    assign ld_fire   = (state_q == WAIT_LD) && ld_valid;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wb_en_d      = 1'b0;
        dest_d       = dest_q;
        value_d      = value_q;
        pend_valid_d = pend_valid_q;
        pend_dest_d  = pend_dest_q;
        ld_err_d     = ld_err_q;
        case (state_q)
            IDLE, WRITE: begin
                state_d = IDLE;
                if (accept && mem_wb_en) begin
                    if (mem_read_en) begin
                        state_d      = WAIT_LD;
                        pend_valid_d = 1'b1;
                        pend_dest_d  = mem_dest;
                        cnt_d        = 8'd0;
                    end else begin
                        state_d = WRITE;
                        wb_en_d = 1'b1;
                        dest_d  = mem_dest;
                        value_d = alu_result;
                    end
                end
            end
            WAIT_LD: begin
                cnt_d = cnt_q + 8'd1;
                // Data arriving in the last allowed cycle still wins over the timeout.
                if (ld_valid) begin
                    pend_valid_d = 1'b0;
                    dest_d       = pend_dest_q;
                    value_d      = ld_data;
`ifdef WB_LOAD_BYPASS_EN
                    state_d      = IDLE;
`else
                    state_d      = WRITE;
                    wb_en_d      = 1'b1;
`endif
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d      = IDLE;
                    pend_valid_d = 1'b0;
                    ld_err_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            wb_en_q      <= 1'b0;
            dest_q       <= 4'd0;
            value_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_dest_q  <= 4'd0;
            ld_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wb_en_q      <= wb_en_d;
            dest_q       <= dest_d;
            value_q      <= value_d;
            pend_valid_q <= pend_valid_d;
            pend_dest_q  <= pend_dest_d;
            ld_err_q     <= ld_err_d;
        end
    end

`ifdef WB_LOAD_BYPASS_EN
    // Load data goes straight to the write port in its arrival cycle.
    assign writeBackEn = wb_en_q || ld_fire;
    assign destWB      = ld_fire ? pend_dest_q : dest_q;
    assign valueWB     = ld_fire ? ld_data : value_q;
`else
    assign writeBackEn = wb_en_q;
    assign destWB      = dest_q;
    assign valueWB     = value_q;
`endif
    assign pend_valid  = pend_valid_q;
    assign pend_dest   = pend_dest_q;
    assign ld_err      = ld_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of the write-back rules.
module tb_wb_stage;

    localparam int DATA_W     = 32;
    localparam int LD_TIMEOUT = 15;
`ifdef WB_LOAD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              mem_valid = 1'b0;
    logic              mem_ready;
    logic              mem_wb_en = 1'b0;
    logic              mem_read_en = 1'b0;
    logic [3:0]        mem_dest = 4'd0;
    logic [DATA_W-1:0] alu_result = '0;
    logic              ld_valid = 1'b0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              writeBackEn;
    logic [3:0]        destWB;
    logic [DATA_W-1:0] valueWB;
    logic              pend_valid;
    logic [3:0]        pend_dest;
    logic              ld_err;

    wb_stage #(.DATA_W(DATA_W), .LD_TIMEOUT(LD_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_wb_en(mem_wb_en), .mem_read_en(mem_read_en),
        .mem_dest(mem_dest), .alu_result(alu_result),
        .ld_valid(ld_valid), .ld_data(ld_data),
        .writeBackEn(writeBackEn), .destWB(destWB), .valueWB(valueWB),
        .pend_valid(pend_valid), .pend_dest(pend_dest), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an outstanding-load flag with a count of cycles waited,
    // plus the last write presented on the register-file port.
    bit              m_wait = 1'b0;
    int              m_waited = 0;
    bit              m_wen = 1'b0;
    logic [3:0]      m_dest = 4'd0;
    logic [DATA_W-1:0] m_val = '0;
    logic [3:0]      m_pd = 4'd0;
    bit              m_err = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_wait   <= 1'b0;
            m_waited <= 0;
            m_wen    <= 1'b0;
            m_dest   <= 4'd0;
            m_val    <= '0;
            m_pd     <= 4'd0;
            m_err    <= 1'b0;
        end else begin
            m_wen <= 1'b0;
            if (m_wait) begin
                m_waited <= m_waited + 1;
                if (ld_valid) begin
                    m_wait <= 1'b0;
                    m_dest <= m_pd;
                    m_val  <= ld_data;
                    m_wen  <= !BYPASS;
                end else if (m_waited + 1 == LD_TIMEOUT) begin
                    m_wait <= 1'b0;
                    m_err  <= 1'b1;
                end
            end else if (mem_valid && mem_wb_en) begin
                if (mem_read_en) begin
                    m_wait   <= 1'b1;
                    m_waited <= 0;
                    m_pd     <= mem_dest;
                end else begin
                    m_wen  <= 1'b1;
                    m_dest <= mem_dest;
                    m_val  <= alu_result;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic fire;
            fire = BYPASS && m_wait && ld_valid && rst;
            check("mem_ready",   mem_ready,   !m_wait);
            check("writeBackEn", writeBackEn, m_wen || fire);
            check("destWB",      destWB,      fire ? m_pd : m_dest);
            check("valueWB",     valueWB,     fire ? ld_data : m_val);
            check("pend_valid",  pend_valid,  m_wait);
            check("pend_dest",   pend_dest,   m_pd);
            check("ld_err",      ld_err,      m_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        mem_valid   = 1'b0;
        mem_wb_en   = 1'b0;
        mem_read_en = 1'b0;
        ld_valid    = 1'b0;
    endtask

    task automatic send(input logic wb, input logic rd, input logic [3:0] d, input logic [DATA_W-1:0] v);
        mem_valid   = 1'b1;
        mem_wb_en   = wb;
        mem_read_en = rd;
        mem_dest    = d;
        alu_result  = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_wben",  writeBackEn, 1'b0);
        check("rst_dest",  destWB, 4'd0);
        check("rst_value", valueWB, 32'd0);
        check("rst_pend",  pend_valid, 1'b0);
        check("rst_err",   ld_err, 1'b0);
        check("rst_ready", mem_ready, 1'b1);
        step();
        rst = 1'b1;
        step();

        // ALU op to r3
        send(1'b1, 1'b0, 4'd3, 32'h0000_00A5);
        step();
        idle_in();
        @(negedge clk);
        check("alu_wben",  writeBackEn, 1'b1);
        check("alu_dest",  destWB, 4'd3);
        check("alu_value", valueWB, 32'hA5);
        step();
        @(negedge clk);
        check("alu_wben_off", writeBackEn, 1'b0);
        check("alu_hold",     valueWB, 32'hA5);

        // Load to r7, data four cycles after accept; MEM keeps offering meanwhile
        step();
        send(1'b1, 1'b1, 4'd7, 32'h1000);
        step();
        send(1'b1, 1'b0, 4'd9, 32'h5555);
        @(negedge clk);
        check("ld_pend",      pend_valid, 1'b1);
        check("ld_pend_dest", pend_dest, 4'd7);
        check("ld_ready",     mem_ready, 1'b0);
        step();
        step();
        step();
        idle_in();
        ld_valid = 1'b1;
        ld_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        check("ld_ready_data", mem_ready, 1'b0);
`ifdef WB_LOAD_BYPASS_EN
        check("ld_byp_wben",  writeBackEn, 1'b1);
        check("ld_byp_dest",  destWB, 4'd7);
        check("ld_byp_value", valueWB, 32'hDEAD_BEEF);
        step();
        ld_valid = 1'b0;
        @(negedge clk);
        check("ld_byp_after", writeBackEn, 1'b0);
        check("ld_pend_drop", pend_valid, 1'b0);
`else
        check("ld_wben_early", writeBackEn, 1'b0);
        step();
        ld_valid = 1'b0;
        @(negedge clk);
        check("ld_wben",      writeBackEn, 1'b1);
        check("ld_dest",      destWB, 4'd7);
        check("ld_value",     valueWB, 32'hDEAD_BEEF);
        check("ld_pend_drop", pend_valid, 1'b0);
        step();
        @(negedge clk);
        check("ld_wben_off", writeBackEn, 1'b0);
`endif

        // Back-to-back ALU ops r1, r2, r3
        step();
        send(1'b1, 1'b0, 4'd1, 32'h11);
        step();
        send(1'b1, 1'b0, 4'd2, 32'h22);
        @(negedge clk);
        check("b2b1_wben", writeBackEn, 1'b1);
        check("b2b1_dest", destWB, 4'd1);
        check("b2b1_val",  valueWB, 32'h11);
        check("b2b1_rdy",  mem_ready, 1'b1);
        step();
        send(1'b1, 1'b0, 4'd3, 32'h33);
        @(negedge clk);
        check("b2b2_wben", writeBackEn, 1'b1);
        check("b2b2_dest", destWB, 4'd2);
        check("b2b2_val",  valueWB, 32'h22);
        check("b2b2_rdy",  mem_ready, 1'b1);
        step();
        idle_in();
        @(negedge clk);
        check("b2b3_wben", writeBackEn, 1'b1);
        check("b2b3_dest", destWB, 4'd3);
        check("b2b3_val",  valueWB, 32'h33);
        step();
        @(negedge clk);
        check("b2b_end", writeBackEn, 1'b0);

        // Load that never returns data
        send(1'b1, 1'b1, 4'd5, 32'h0);
        step();
        idle_in();
        for (int i = 0; i < LD_TIMEOUT - 1; i++) step();
        @(negedge clk);
        check("to_still_pend", pend_valid, 1'b1);
        check("to_no_err",     ld_err, 1'b0);
        step();
        @(negedge clk);
        check("to_err",   ld_err, 1'b1);
        check("to_pend",  pend_valid, 1'b0);
        check("to_ready", mem_ready, 1'b1);
        check("to_wben",  writeBackEn, 1'b0);

        // Store (no write), then reset while a load is pending
        step();
        send(1'b0, 1'b1, 4'd8, 32'h77);
        step();
        idle_in();
        @(negedge clk);
        check("st_wben",  writeBackEn, 1'b0);
        check("st_ready", mem_ready, 1'b1);
        step();
        send(1'b1, 1'b1, 4'd6, 32'h0);
        step();
        idle_in();
        @(negedge clk);
        check("rl_pend", pend_valid, 1'b1);
        step();
        rst = 1'b0;
        #1;
        check("rl_wben",  writeBackEn, 1'b0);
        check("rl_dest",  destWB, 4'd0);
        check("rl_value", valueWB, 32'd0);
        check("rl_pend0", pend_valid, 1'b0);
        check("rl_pdest", pend_dest, 4'd0);
        check("rl_err",   ld_err, 1'b0);
        check("rl_ready", mem_ready, 1'b1);
        step();
        step();
        rst      = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 32'hCAFE_F00D;
        step();
        ld_valid = 1'b0;
        @(negedge clk);
        check("rl_no_write", writeBackEn, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step();
            rst         = ($urandom_range(0, 299) != 0);
            mem_valid   = $urandom_range(0, 1) == 1;
            mem_wb_en   = $urandom_range(0, 3) != 0;
            mem_read_en = $urandom_range(0, 4) < 2;
            mem_dest    = 4'($urandom);
            alu_result  = $urandom;
            ld_valid    = $urandom_range(0, 6) == 0;
            ld_data     = $urandom;
        end
        step();
        rst = 1'b1;
        idle_in();
        step();
        @(negedge clk);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
